// File: rtl/alu_explicit_pkg.sv
// Shared definitions for the alu_explicit block.
//   DATA_W        : operand and result width (32)
//   opcode_t      : 4-bit operation encoding; encodings 10-15 are unassigned
//   instruction_t : packed instruction word {opcode, a, b}
// Optional feature: the multiplier, enabled by defining ALU_MUL_EN.
package alu_explicit_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        MUL   = 4'd2,
        AND   = 4'd3,
        OR    = 4'd4,
        XOR   = 4'd5,
        SLL   = 4'd6,
        SRL   = 4'd7,
        PASSA = 4'd8,
        NOP   = 4'd9
    } opcode_t;

    typedef struct packed {
        opcode_t             opcode;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
    } instruction_t;

endpackage

// File: rtl/alu_explicit_core.sv
// alu_core: purely combinational operation select.
//   opcode  in  : operation to perform
//   a, b    in  : unsigned operands
//   value   out : operation result (0 for NOP and for unexecuted opcodes)
//   illegal out : 1 when the opcode is not executed by this build
// MUL is only present when ALU_MUL_EN is defined; otherwise it falls into
// the illegal branch and no multiplier is built.
module alu_core
    import alu_explicit_pkg::*;
(
    input  opcode_t             opcode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   value,
    output logic                illegal
);

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (opcode)
            ADD:   value = a + b;
            SUB:   value = a - b;
`ifdef ALU_MUL_EN
            MUL:   value = a * b;
`endif
            AND:   value = a & b;
            OR:    value = a | b;
            XOR:   value = a ^ b;
            // Shift amount is b[4:0]; upper bits of b are deliberately ignored.
            SLL:   value = a << b[4:0];
            SRL:   value = a >> b[4:0];
            PASSA: value = a;
            NOP:   value = '0;
            default: begin
                value   = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_explicit.sv
// alu_explicit: single-cycle registered ALU.
//   clock   in  : rising-edge clock
//   reset   in  : asynchronous, active-high reset
//   IW      in  : instruction word {opcode, a, b}, accepted every cycle
//   result  out : registered result, 1 cycle after IW is captured
//   illegal out : registered flag, 1 when the captured opcode is not executed
// Parameter RESET_VALUE: value forced onto result while reset is high.
// Optional feature: define ALU_MUL_EN to implement MUL (see alu_core).
module alu_explicit
    import alu_explicit_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic                clock,
    input  logic                reset,
    input  instruction_t        IW,
    output logic [DATA_W-1:0]   result,
    output logic                illegal
);

    logic [DATA_W-1:0] core_value;
    logic              core_illegal;
    logic [DATA_W-1:0] result_d, result_q;
    logic              illegal_d, illegal_q;

    alu_core u_core (
        .opcode  (IW.opcode),
        .a       (IW.a),
        .b       (IW.b),
        .value   (core_value),
        .illegal (core_illegal)
    );

    // NOP keeps the previous result; everything else loads the core output.
    always_comb begin
        result_d  = core_value;
        illegal_d = core_illegal;
        if (IW.opcode == NOP) begin
            result_d = result_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q  <= RESET_VALUE;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_explicit.sv
// Self-checking bench for alu_explicit. Expected {illegal, result} pairs are
// pushed to a queue when an instruction is driven and popped after the
// capturing clock edge. Define ALU_MUL_EN to match the DUT build.
module tb_alu_explicit;
    import alu_explicit_pkg::*;

    logic         clock;
    logic         reset;
    instruction_t IW;
    logic [31:0]  result;
    logic         illegal;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];
    logic [31:0] model_prev;

    alu_explicit #(.RESET_VALUE(32'd0)) dut (
        .clock   (clock),
        .reset   (reset),
        .IW      (IW),
        .result  (result),
        .illegal (illegal)
    );

    // First rising edge at 10 ns, period 10 ns.
    initial begin
        clock = 1'b0;
        #10 clock = 1'b1;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference: returns {illegal, result}.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] prev);
        case (op)
            4'd0: return {1'b0, a + b};
            4'd1: return {1'b0, a - b};
`ifdef ALU_MUL_EN
            4'd2: return {1'b0, 32'(64'(a) * 64'(b))};
`else
            4'd2: return {1'b1, 32'd0};
`endif
            4'd3: return {1'b0, a & b};
            4'd4: return {1'b0, a | b};
            4'd5: return {1'b0, a ^ b};
            4'd6: return {1'b0, a << (b % 32)};
            4'd7: return {1'b0, a >> (b % 32)};
            4'd8: return {1'b0, a};
            4'd9: return {1'b0, prev};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Drive one instruction, queue its expectation, check after the edge.
    task automatic step(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        logic [32:0] e;
        IW.opcode = opcode_t'(op);
        IW.a      = a;
        IW.b      = b;
        e = model(op, a, b, model_prev);
        exp_q.push_back(e);
        model_prev = e[31:0];
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_res"}, result, e[31:0]);
            chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, e[32]});
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        reset      = 1'b1;
        IW         = '0;
        model_prev = 32'd0;

        #3;
        chk("rst_res", result, 32'd0);
        chk("rst_ill", {31'd0, illegal}, 32'd0);
        #2 reset = 1'b0;

        step("add_10_15", 4'd0, 32'd10, 32'd15);
        step("sub_20_5", 4'd1, 32'd20, 32'd5);
        step("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
        step("sub_wrap", 4'd1, 32'd0, 32'd1);
        step("sll_1_33", 4'd6, 32'd1, 32'd33);
        step("srl_msb_31", 4'd7, 32'h8000_0000, 32'd31);
        step("and", 4'd3, 32'hF0F0_1234, 32'h0FF0_FF00);
        step("or", 4'd4, 32'hF0F0_1234, 32'h0FF0_FF00);
        step("xor", 4'd5, 32'hF0F0_1234, 32'h0FF0_FF00);
        step("passa", 4'd8, 32'hDEAD_BEEF, 32'h1234_5678);
        step("nop_hold", 4'd9, 32'd1, 32'd2);
        step("mul_6_7", 4'd2, 32'd6, 32'd7);
        step("op12", 4'd12, 32'd5, 32'd6);
        step("nop_after_illegal", 4'd9, 32'd5, 32'd6);
        step("op15", 4'd15, 32'd1, 32'd1);

        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom();
            rb  = $urandom();
            step($sformatf("rnd%0d", i), rop, ra, rb);
        end

        // Asynchronous reset mid-cycle after result=25.
        step("pre_rst_add", 4'd0, 32'd10, 32'd15);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_res", result, 32'd0);
        chk("async_rst_ill", {31'd0, illegal}, 32'd0);
        IW.opcode = ADD;
        IW.a      = 32'd3;
        IW.b      = 32'd4;
        @(posedge clock);
        #1;
        chk("rst_edge_res", result, 32'd0);
        #3 reset = 1'b0;
        model_prev = 32'd0;
        step("post_rst_add", 4'd0, 32'd3, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_explicit.md
ALU_EXPLICIT -- requirements
Module: alu_explicit

Interface
- REQ-001: Parameter RESET_VALUE SHALL be declared as: RESET_VALUE, 32'd0, value loaded into result while reset is asserted.
- REQ-002: Port clock SHALL be: clock  input  1  single clock; all state updates on its rising edge.
- REQ-003: Port reset SHALL be: reset  input  1  asynchronous, active-high reset.
- REQ-004: Port IW SHALL be: IW  input  instruction_t  packed instruction word {opcode, a[31:0], b[31:0]}.
- REQ-005: Port result SHALL be: result  output  32  registered operation result.
- REQ-006: Port illegal SHALL be: illegal  output  1  registered flag; 1 when the captured opcode is not executed.
- REQ-007: The block SHALL have one clock and an asynchronous, active-high reset, with the ports named clock and reset.

Function
- REQ-008: On each rising clock edge with reset low, the block SHALL compute f(IW.opcode, IW.a, IW.b) and register it into result; latency is exactly 1 cycle, with no handshake and a new instruction accepted every cycle.
- REQ-009: ADD SHALL produce a+b modulo 2^32, with carry discarded (32'hFFFFFFFF+1 -> 0).
- REQ-010: SUB SHALL produce a-b in two's complement modulo 2^32 (0-1 -> 32'hFFFFFFFF).
- REQ-011: MUL SHALL produce the low 32 bits of unsigned a*b; it exists only per REQ-020.
- REQ-012: AND, OR and XOR SHALL produce the bitwise a&b, a|b and a^b.
- REQ-013: SLL and SRL SHALL produce the logical shift of a by b[4:0]; b[31:5] is ignored.
- REQ-014: PASSA SHALL produce a.
- REQ-015: NOP SHALL hold result at its previous value and clear illegal to 0.
- REQ-016: Any opcode encoding not listed SHALL load result with 0 and set illegal to 1; executed opcodes SHALL clear illegal to 0.
- REQ-017: Operands SHALL be treated as unsigned; no flags other than illegal are produced.

Reset
- REQ-018: Asserting reset SHALL immediately, without waiting for a clock edge, force result to RESET_VALUE and illegal to 0, overriding any in-flight instruction.
- REQ-019: While reset is high, clock edges SHALL have no effect; the first rising edge after deassertion SHALL capture IW normally.

Configuration
- REQ-020: Macro ALU_MUL_EN, when defined, SHALL implement MUL per REQ-011; when undefined, the MUL encoding SHALL be treated as illegal per REQ-016 (result 0, illegal 1) and no multiplier SHALL be synthesized.

Structure
- REQ-021: Package definitions SHALL contain opcode_t, an enum of 4-bit encodings: ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, PASSA=8, NOP=9; encodings 10-15 are unassigned.
- REQ-022: Package definitions SHALL also contain instruction_t, a packed struct {opcode_t opcode; logic [31:0] a; logic [31:0] b;}, and the operand width constant 32.
- REQ-023: Combinational operation selection SHALL sit in one sub-module alu_core (inputs opcode, a, b; outputs value, illegal); alu_explicit SHALL register its outputs.

Verification
- REQ-024: The bench SHALL check that reset held for 5 ns with RESET_VALUE=0 gives result=0 and illegal=0 before the first clock edge.
- REQ-025: The bench SHALL check that ADD a=10, b=15 applied before the edge at 10 ns gives result=25 after that edge; then SUB a=20, b=5 gives result=15 after the next edge.
- REQ-026: The bench SHALL check the wrap cases: ADD 32'hFFFFFFFF+1 -> 0, SUB 0-1 -> 32'hFFFFFFFF, and SLL a=1, b=33 -> 2.
- REQ-027: The bench SHALL check that MUL a=6, b=7 gives 42 with ALU_MUL_EN defined, and gives result=0, illegal=1 without it.
- REQ-028: The bench SHALL check that opcode 12 gives result=0, illegal=1, and that a following NOP keeps result=0 with illegal=0.
- REQ-029: The bench SHALL check that reset asserted mid-cycle after result=25 forces result to 0 immediately, and that the first edge after release loads the current IW.
